// File: rtl/ddr_init_ins_exec_if.sv
// Instruction stream and DDR application-port bundle for ddr_init_ins_exec.
// master = instruction source / DDR controller side, slave = the executor.
interface ddr_init_ins_exec_if;
  logic         data_init_ins_vld;
  logic [160:0] data_init_ins;
  logic         ins_ready;

  logic         app_en;
  logic [2:0]   app_cmd;
  logic [27:0]  app_addr;
  logic         app_rdy;

  logic [127:0] app_wdf_data;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_rdy;

  modport master (
    output data_init_ins_vld, data_init_ins, app_rdy, app_wdf_rdy,
    input  ins_ready, app_en, app_cmd, app_addr,
           app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask
  );

  modport slave (
    input  data_init_ins_vld, data_init_ins, app_rdy, app_wdf_rdy,
    output ins_ready, app_en, app_cmd, app_addr,
           app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask
  );
endinterface

// File: rtl/ddr_init_ins_exec.sv
// DDR init instruction executor: buffers {data, addr} write beats in a FIFO
// and replays each one as a single 128-bit write on the DDR app port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | FIFO empty (or just filled); waiting for work or finish
// S_ISSUE | head entry on app port; command and data handshakes pending
// S_DONE  | finish seen and every write retired; terminal until reset
module ddr_init_ins_exec #(
  parameter int FIFO_DEPTH   = 16,
  parameter int READY_MARGIN = 4
) (
  input  logic               clk_200M,
  input  logic               rst_n,
  ddr_init_ins_exec_if.slave bus,
  output logic               ddr_init_done,
  output logic [19:0]        wr_cnt,
  output logic               ovf_err,
  output logic               bl_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  // Only addr[24:0] survives the *8 into a 28-bit app_addr, so only those bits are stored.
  localparam int EW = 128 + 25;
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] READY_TH = (AW+1)'(FIFO_DEPTH - READY_MARGIN);
  localparam logic [AW:0] ONE_C    = (AW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  logic [3:0]   ins_bl;
  logic [24:0]  ins_addr;
  logic [127:0] ins_data;
  logic         ins_fin;
  logic         unused_addr_hi;

  assign ins_bl         = bus.data_init_ins[3:0];
  assign ins_addr       = bus.data_init_ins[28:4];
  assign ins_data       = bus.data_init_ins[159:32];
  assign ins_fin        = bus.data_init_ins[160];
  assign unused_addr_hi = ^bus.data_init_ins[31:29];

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count, count_d;
  logic          full, push_req, push_ok, pop;
  logic [AW-1:0] rd_idx, rd_idx_nx;
  logic [EW-1:0] head, head_nx;

  state_t        state_q, state_d;
  logic          en_q, en_d;
  logic          wren_q, wren_d;
  logic [27:0]   addr_q, addr_d;
  logic [127:0]  data_q, data_d;
  logic [19:0]   cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic          blerr_q, blerr_d;
  logic          fin_q, fin_d;
  logic          cmd_ok, dat_ok;

  assign count     = wr_ptr_q - rd_ptr_q;
  assign full      = (count == DEPTH_C);
  assign push_req  = bus.data_init_ins_vld && (ins_bl != 4'd0);
  assign push_ok   = push_req && !full;
  assign rd_idx    = rd_ptr_q[AW-1:0];
  assign rd_idx_nx = rd_idx + AW'(1);
  assign head      = mem_q[rd_idx];
  assign head_nx   = mem_q[rd_idx_nx];

  // A side counts as accepted once its strobe has dropped or it handshakes now.
  assign cmd_ok = !en_q   || bus.app_rdy;
  assign dat_ok = !wren_q || bus.app_wdf_rdy;

  // FIFO storage; occupancy guards every read, so the array needs no reset.
  always_ff @(posedge clk_200M) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {ins_data, ins_addr};
    end
  end

  // Write FSM: next state, output register loads and FIFO pop.
  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    wren_d  = wren_q;
    addr_d  = addr_q;
    data_d  = data_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count != '0) begin
          state_d = S_ISSUE;
          en_d    = 1'b1;
          wren_d  = 1'b1;
          addr_d  = {head[24:0], 3'b000};
          data_d  = head[EW-1:25];
        end else if (fin_q) begin
          state_d = S_DONE;
        end
      end
      S_ISSUE: begin
        if (bus.app_rdy)     en_d   = 1'b0;
        if (bus.app_wdf_rdy) wren_d = 1'b0;
        if (cmd_ok && dat_ok) begin
          pop = 1'b1;
          // Chain only on entries already stored; a beat landing this edge
          // is picked up from IDLE on the following cycle.
          if (count > ONE_C) begin
            en_d   = 1'b1;
            wren_d = 1'b1;
            addr_d = {head_nx[24:0], 3'b000};
            data_d = head_nx[EW-1:25];
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Occupancy, ready, write count and sticky status next-state.
  always_comb begin
    count_d = count + (push_ok ? ONE_C : '0) - (pop ? ONE_C : '0);
    ready_d = (count_d <= READY_TH);
    done_d  = (state_d == S_DONE);
    cnt_d   = (pop && (cnt_q != 20'hFFFFF)) ? cnt_q + 20'd1 : cnt_q;
    ovf_d   = ovf_q | (push_req & full);
    blerr_d = blerr_q | (bus.data_init_ins_vld & (ins_bl > 4'd1));
    fin_d   = fin_q | ins_fin;
  end

  // State, pointers and output registers; async reset abandons any in-flight write.
  always_ff @(posedge clk_200M or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      en_q     <= 1'b0;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      blerr_q  <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_q + (push_ok ? ONE_C : '0);
      rd_ptr_q <= rd_ptr_q + (pop ? ONE_C : '0);
      en_q     <= en_d;
      wren_q   <= wren_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      blerr_q  <= blerr_d;
      fin_q    <= fin_d;
    end
  end

  assign bus.ins_ready    = ready_q;
  assign bus.app_en       = en_q;
  assign bus.app_cmd      = 3'b000;
  assign bus.app_addr     = addr_q;
  assign bus.app_wdf_data = data_q;
  assign bus.app_wdf_wren = wren_q;
  assign bus.app_wdf_end  = wren_q;
  assign bus.app_wdf_mask = 16'h0000;
  assign ddr_init_done    = done_q;
  assign wr_cnt           = cnt_q;
  assign ovf_err          = ovf_q;
  assign bl_err           = blerr_q;

endmodule

// File: tb/tb_ddr_init_ins_exec.sv
// Bench for ddr_init_ins_exec: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based model of the executor.
module tb_ddr_init_ins_exec;
  localparam int DEPTH  = 16;
  localparam int MARGIN = 4;

  logic clk_200M = 1'b0;
  logic rst_n    = 1'b1;
  always #5 clk_200M = ~clk_200M;

  ddr_init_ins_exec_if bus ();
  logic        ddr_init_done;
  logic [19:0] wr_cnt;
  logic        ovf_err, bl_err;

  ddr_init_ins_exec #(.FIFO_DEPTH(DEPTH), .READY_MARGIN(MARGIN)) dut (
    .clk_200M     (clk_200M),
    .rst_n        (rst_n),
    .bus          (bus),
    .ddr_init_done(ddr_init_done),
    .wr_cnt       (wr_cnt),
    .ovf_err      (ovf_err),
    .bl_err       (bl_err)
  );

  int checks = 0;
  int errors = 0;

  // model state: queue of {data, addr} beats held by the executor
  logic [155:0] mq[$];
  int           m_cnt;
  bit           m_ovf, m_blerr, m_fin, cmd_done, dat_done, m_done_prev;
  int           idle_run, done_run, n_en, n_wr;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [160:0] mk_ins(input logic fin, input logic [127:0] d,
                                          input logic [27:0] a, input logic [3:0] bl);
    return {fin, d, a, bl};
  endfunction

  task automatic model_clear();
    mq.delete();
    m_cnt = 0; m_ovf = 0; m_blerr = 0; m_fin = 0;
    cmd_done = 0; dat_done = 0; m_done_prev = 0;
    idle_run = 0; done_run = 0;
  endtask

  task automatic check_outputs();
    chk("ins_ready", bus.ins_ready, mq.size() <= DEPTH - MARGIN);
    chk("wr_cnt", wr_cnt, 20'(m_cnt));
    chk("ovf_err", ovf_err, m_ovf);
    chk("bl_err", bl_err, m_blerr);
    chk("app_cmd", bus.app_cmd, 3'b000);
    chk("app_wdf_mask", bus.app_wdf_mask, 16'h0);
    chk("app_wdf_end", bus.app_wdf_end, bus.app_wdf_wren);
    if (bus.app_en) begin
      n_en++;
      chk("en_with_entry", mq.size() != 0, 1'b1);
      chk("en_after_accept", cmd_done, 1'b0);
      if (mq.size() != 0) chk("app_addr", bus.app_addr, 28'(mq[0][27:0] * 8));
    end
    if (bus.app_wdf_wren) begin
      n_wr++;
      chk("wren_with_entry", mq.size() != 0, 1'b1);
      chk("wren_after_accept", dat_done, 1'b0);
      if (mq.size() != 0) chk("app_wdf_data", bus.app_wdf_data, mq[0][155:28]);
    end
    if (mq.size() != 0 && !bus.app_en && !bus.app_wdf_wren) idle_run++;
    else idle_run = 0;
    chk("issue_stall", idle_run > 1, 1'b0);
    if (ddr_init_done) chk("done_early", m_fin && (mq.size() == 0), 1'b1);
    chk("done_sticky", m_done_prev && !ddr_init_done, 1'b0);
    if (m_fin && mq.size() == 0 && !ddr_init_done) done_run++;
    else done_run = 0;
    chk("done_latency", done_run > 2, 1'b0);
    m_done_prev = ddr_init_done;
  endtask

  // Advance the model across the coming rising edge, given the inputs just driven.
  task automatic model_update(input logic v, input logic [160:0] ins, input logic r, input logic w);
    bit cacc, dacc, inflight;
    int pre;
    cacc     = bus.app_en && r;
    dacc     = bus.app_wdf_wren && w;
    inflight = bus.app_en || bus.app_wdf_wren || cmd_done || dat_done;
    pre      = mq.size();
    if (inflight && (cmd_done || cacc) && (dat_done || dacc)) begin
      void'(mq.pop_front());
      if (m_cnt < 20'hFFFFF) m_cnt++;
      cmd_done = 0;
      dat_done = 0;
    end else begin
      cmd_done = cmd_done || cacc;
      dat_done = dat_done || dacc;
    end
    if (v && ins[3:0] != 4'd0) begin
      if (pre < DEPTH) mq.push_back({ins[159:32], ins[31:4]});
      else m_ovf = 1;
    end
    if (v && ins[3:0] > 4'd1) m_blerr = 1;
    if (ins[160]) m_fin = 1;
  endtask

  task automatic step(input logic v, input logic [160:0] ins, input logic r, input logic w);
    @(negedge clk_200M);
    check_outputs();
    bus.data_init_ins_vld = v;
    bus.data_init_ins     = ins;
    bus.app_rdy           = r;
    bus.app_wdf_rdy       = w;
    model_update(v, ins, r, w);
  endtask

  task automatic idle(input int n, input logic r, input logic w);
    for (int i = 0; i < n; i++) step(1'b0, '0, r, w);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.data_init_ins_vld = 1'b0;
    bus.data_init_ins     = '0;
    bus.app_rdy           = 1'b0;
    bus.app_wdf_rdy       = 1'b0;
    #1;
    chk("rst_app_en", bus.app_en, 1'b0);
    chk("rst_wren", bus.app_wdf_wren, 1'b0);
    chk("rst_wdf_end", bus.app_wdf_end, 1'b0);
    chk("rst_app_addr", bus.app_addr, 28'h0);
    chk("rst_wdf_data", bus.app_wdf_data, 128'h0);
    chk("rst_ins_ready", bus.ins_ready, 1'b1);
    chk("rst_done", ddr_init_done, 1'b0);
    chk("rst_wr_cnt", wr_cnt, 20'h0);
    chk("rst_ovf", ovf_err, 1'b0);
    chk("rst_bl_err", bl_err, 1'b0);
    model_clear();
    @(negedge clk_200M);
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] rd;
    int pushed;
    int thr;
    logic v, r, w;
    logic [3:0] bl;
    #2;
    do_reset();

    // single beat, addr 5
    n_en = 0; n_wr = 0;
    step(1'b1, mk_ins(1'b0, {4{32'hA5A5A5A5}}, 28'd5, 4'd1), 1'b1, 1'b1);
    idle(2, 1'b1, 1'b1);
    chk("single_app_en", bus.app_en, 1'b1);
    chk("single_app_addr", bus.app_addr, 28'd40);
    chk("single_data", bus.app_wdf_data, {4{32'hA5A5A5A5}});
    idle(4, 1'b1, 1'b1);
    chk("single_wr_cnt", wr_cnt, 20'd1);
    chk("single_en_pulses", n_en, 1);
    chk("single_wren_pulses", n_wr, 1);

    // independent handshakes: app_rdy in cycle 2, app_wdf_rdy in cycle 5
    step(1'b1, mk_ins(1'b0, 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978, 28'd7, 4'd1), 1'b0, 1'b0);
    idle(1, 1'b0, 1'b0);
    n_en = 0; n_wr = 0;
    for (int k = 1; k <= 6; k++) step(1'b0, '0, k == 2, k == 5);
    idle(1, 1'b0, 1'b0);
    chk("split_en_cycles", n_en, 2);
    chk("split_wren_cycles", n_wr, 5);
    chk("split_wr_cnt", wr_cnt, 20'd2);

    // fill with the DDR side stalled, then overflow, then release
    for (int i = 0; i < 17; i++) begin
      step(1'b1, mk_ins(1'b0, {$urandom, $urandom, $urandom, $urandom}, 28'(100 + i), 4'd1), 1'b0, 1'b0);
      if (i == 12) chk("ready_at_occ12", bus.ins_ready, 1'b1);
      if (i == 13) chk("ready_at_occ13", bus.ins_ready, 1'b0);
    end
    idle(1, 1'b0, 1'b0);
    chk("ovf_set", ovf_err, 1'b1);
    n_en = 0;
    idle(17, 1'b1, 1'b1);
    chk("fill_wr_cnt", wr_cnt, 20'd18);
    chk("fill_back_to_back", n_en, 16);
    chk("fill_ready_back", bus.ins_ready, 1'b1);

    // 288-beat stream, then finish
    do_reset();
    pushed = 0;
    for (int i = 0; i < 5000 && pushed < 288; i++) begin
      v  = bus.ins_ready;
      rd = {$urandom, $urandom, $urandom, $urandom};
      step(v, mk_ins(1'b0, rd, 28'(pushed), 4'd1), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      if (v) pushed++;
    end
    chk("stream_pushed", pushed, 288);
    step(1'b0, mk_ins(1'b1, '0, '0, 4'd0), 1'b1, 1'b1);
    for (int i = 0; i < 1000 && !ddr_init_done; i++) step(1'b0, '0, 1'b1, 1'b1);
    chk("stream_done", ddr_init_done, 1'b1);
    chk("stream_wr_cnt", wr_cnt, 20'd288);
    chk("stream_no_ovf", ovf_err, 1'b0);
    idle(3, 1'b1, 1'b1);
    chk("done_held", ddr_init_done, 1'b1);

    // burst-length handling
    do_reset();
    step(1'b1, mk_ins(1'b0, 128'h1111, 28'd3, 4'd0), 1'b1, 1'b1);
    idle(4, 1'b1, 1'b1);
    chk("bl0_no_write", wr_cnt, 20'd0);
    chk("bl0_no_err", bl_err, 1'b0);
    step(1'b1, mk_ins(1'b0, 128'h2222, 28'd9, 4'd2), 1'b1, 1'b1);
    idle(5, 1'b1, 1'b1);
    chk("bl2_one_write", wr_cnt, 20'd1);
    chk("bl2_err", bl_err, 1'b1);

    // reset in the middle of ISSUE
    do_reset();
    step(1'b1, mk_ins(1'b0, 128'h3333, 28'd11, 4'd1), 1'b0, 1'b0);
    idle(2, 1'b0, 1'b0);
    chk("midrst_in_issue", bus.app_en, 1'b1);
    do_reset();
    step(1'b1, mk_ins(1'b0, 128'h4444, 28'd12, 4'd1), 1'b1, 1'b1);
    idle(4, 1'b1, 1'b1);
    chk("midrst_resume_cnt", wr_cnt, 20'd1);

    // randomized traffic with varying back-pressure
    do_reset();
    for (int s = 0; s < 4; s++) begin
      thr = (s == 0) ? 8 : (s == 1) ? 2 : (s == 2) ? 5 : 10;
      for (int i = 0; i < 600; i++) begin
        v  = $urandom_range(0, 1);
        bl = ($urandom_range(0, 7) == 0) ? 4'd0 :
             ($urandom_range(0, 7) == 0) ? 4'($urandom_range(2, 15)) : 4'd1;
        r  = $urandom_range(0, 9) < thr;
        w  = $urandom_range(0, 9) < thr;
        step(v, mk_ins(1'b0, {$urandom, $urandom, $urandom, $urandom}, 28'($urandom), bl), r, w);
      end
    end
    for (int i = 0; i < 200 && mq.size() != 0; i++) step(1'b0, '0, 1'b1, 1'b1);
    chk("rand_drained", mq.size(), 0);
    step(1'b0, mk_ins(1'b1, '0, '0, 4'd0), 1'b1, 1'b1);
    for (int i = 0; i < 10 && !ddr_init_done; i++) step(1'b0, '0, 1'b1, 1'b1);
    chk("rand_done", ddr_init_done, 1'b1);
    idle(2, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
